// File: rtl/lift_ctrl_n.sv
// ----------------------------------------------------------------------------
// lift_ctrl_n -- N-floor lift controller with SCAN request ordering.
//
// Floor requests are latched into a pending bitmap. The car moves one floor
// every TRAVEL_CYCLES clocks and keeps its direction while requests lie ahead,
// otherwise it reverses. At each serviced floor the door stays open for
// DOOR_CYCLES clocks; a request for the open floor re-arms the door timer.
//
// Ports:
//   clk_i           clock, all state updates on the rising edge
//   rst_ni          synchronous reset, active low
//   req_valid_i     request strobe, sampled every edge
//   req_floor_i     requested floor (ignored when >= FLOORS)
//   cur_floor_o     current floor; while moving, the floor being left
//   floor_onehot_o  one-hot decode of cur_floor_o
//   moving_up_o     car travelling upwards
//   moving_down_o   car travelling downwards
//   door_open_o     door open at cur_floor_o
//   pending_o       outstanding request bitmap
// ----------------------------------------------------------------------------
module lift_ctrl_n #(
    parameter int unsigned FLOORS        = 4,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 3,
    localparam int unsigned FW = (FLOORS > 1) ? $clog2(FLOORS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    input  logic [FW-1:0]     req_floor_i,
    output logic [FW-1:0]     cur_floor_o,
    output logic [FLOORS-1:0] floor_onehot_o,
    output logic              moving_up_o,
    output logic              moving_down_o,
    output logic              door_open_o,
    output logic [FLOORS-1:0] pending_o
);

    localparam int unsigned MaxCyc = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TW     = $clog2(MaxCyc) + 1;

    localparam logic [TW-1:0]     TravelLoad = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0]     DoorLoad   = TW'(DOOR_CYCLES - 1);
    localparam logic [FLOORS-1:0] Floor0Mask = FLOORS'(1);

    typedef enum logic [1:0] {StIdle, StMoveUp, StMoveDown, StDoor} state_e;

    state_e            state_q, state_d;
    logic [FW-1:0]     cur_floor_q, cur_floor_d;
    logic [FLOORS-1:0] pending_q, pending_d;
    logic              dir_up_q, dir_up_d;
    logic [TW-1:0]     timer_q, timer_d;

    logic [FLOORS-1:0] here_mask;
    logic [FLOORS-1:0] req_set;
    logic [FLOORS-1:0] pend_clr;
    logic              pend_here, pend_above, pend_below;
    logic              pend_next_up, pend_next_dn;
    logic              door_hit, at_top, at_bottom;

    // Request decode and pending-map queries, all from registered state.
    always_comb begin
        req_set    = '0;
        pend_above = 1'b0;
        pend_below = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (req_valid_i && (32'(req_floor_i) == i)) begin
                req_set[i] = 1'b1;
            end
            if (pending_q[i] && (i > 32'(cur_floor_q))) begin
                pend_above = 1'b1;
            end
            if (pending_q[i] && (i < 32'(cur_floor_q))) begin
                pend_below = 1'b1;
            end
        end
        here_mask    = Floor0Mask << cur_floor_q;
        pend_here    = |(pending_q & here_mask);
        pend_next_up = |(pending_q & (here_mask << 1));
        pend_next_dn = |(pending_q & (here_mask >> 1));
        at_top       = (32'(cur_floor_q) == (FLOORS - 1));
        at_bottom    = (cur_floor_q == '0);
        // A call for the floor whose door is open only re-arms the door.
        door_hit     = (state_q == StDoor) && req_valid_i && (req_floor_i == cur_floor_q);
        if (door_hit) begin
            req_set = '0;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cur_floor_q <= '0;
            pending_q   <= '0;
            dir_up_q    <= 1'b1;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            pending_q   <= pending_d;
            dir_up_q    <= dir_up_d;
            timer_q     <= timer_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        timer_d     = timer_q;
        pend_clr    = '0;

        unique case (state_q)
            StIdle: begin
                if (pend_here) begin
                    state_d  = StDoor;
                    pend_clr = here_mask;
                    timer_d  = DoorLoad;
                end else if (pend_above && (dir_up_q || !pend_below)) begin
                    state_d  = StMoveUp;
                    dir_up_d = 1'b1;
                    timer_d  = TravelLoad;
                end else if (pend_below) begin
                    state_d  = StMoveDown;
                    dir_up_d = 1'b0;
                    timer_d  = TravelLoad;
                end
            end

            StMoveUp: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (at_top) begin
                    // Unreachable while a target lies ahead; keeps the car in range.
                    state_d = StIdle;
                end else begin
                    cur_floor_d = cur_floor_q + FW'(1);
                    if (pend_next_up) begin
                        state_d  = StDoor;
                        pend_clr = here_mask << 1;
                        timer_d  = DoorLoad;
                    end else begin
                        timer_d = TravelLoad;
                    end
                end
            end

            StMoveDown: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (at_bottom) begin
                    state_d = StIdle;
                end else begin
                    cur_floor_d = cur_floor_q - FW'(1);
                    if (pend_next_dn) begin
                        state_d  = StDoor;
                        pend_clr = here_mask >> 1;
                        timer_d  = DoorLoad;
                    end else begin
                        timer_d = TravelLoad;
                    end
                end
            end

            StDoor: begin
                if (door_hit) begin
                    timer_d = DoorLoad;
                end else if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // A fresh capture of a bit being cleared survives (door case already filtered).
        pending_d = (pending_q & ~pend_clr) | req_set;
    end

    // Outputs, decoded from registered state only.
    always_comb begin
        cur_floor_o    = cur_floor_q;
        floor_onehot_o = here_mask;
        moving_up_o    = (state_q == StMoveUp);
        moving_down_o  = (state_q == StMoveDown);
        door_open_o    = (state_q == StDoor);
        pending_o      = pending_q;
    end

endmodule
